// File: rtl/bus_arb.sv
// bus_arb: two-master round-robin arbiter for the 24-bit stb/ack system bus with transfer timeout
//
// Ports:
//   clk, rst_n                      system clock, asynchronous active-low reset
//   m0_stb/we/addr/dout -> m0_din/ack   CPU master interface (word address [23:2])
//   m1_stb/we/addr/dout -> m1_din/ack   second master interface, same protocol
//   bus_stb/we/addr/dout, bus_din/ack   shared slave-side interface
//   gnt                             one-hot current grant {m1,m0}, 2'b00 when idle
//   tmo_err                         single-cycle pulse on a forced (timed-out) completion
//   tmo_addr                        byte address of the most recent timed-out transfer
module bus_arb #(
    parameter int          TMO_CYCLES = 255,
    parameter int          TMO_W      = 8,
    parameter logic [31:0] ERR_DATA   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [21:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    output logic        m1_ack,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic [1:0]  gnt,
    output logic        tmo_err,
    output logic [23:0] tmo_addr
);
    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam bit               TMO_EN   = TMO_CYCLES != 0;

    state_t            state_q;
    logic              last_q;
    logic [TMO_W-1:0]  cnt_q;
    logic [23:0]       tmo_addr_q;

    logic        act;
    logic        sel;
    logic        sel_stb;
    logic        done;
    logic        tmo_hit;
    logic        fin;
    logic [21:0] sel_addr;

    always_comb begin
        act      = state_q != IDLE;
        sel      = state_q == G1;
        sel_stb  = sel ? m1_stb : m0_stb;
        sel_addr = sel ? m1_addr : m0_addr;
        // A slave ack only counts while the granted master still strobes;
        // a dropped strobe is an abort regardless of bus_ack.
        done     = act && sel_stb && bus_ack;
        // An ack in the last allowed cycle beats the timeout.
        tmo_hit  = TMO_EN && act && sel_stb && !bus_ack && cnt_q == TMO_LAST;
        fin      = done || tmo_hit;
        bus_stb  = act && sel_stb && !tmo_hit;
        bus_we   = act && (sel ? m1_we : m0_we);
        bus_addr = sel_addr;
        bus_dout = sel ? m1_dout : m0_dout;
        m0_ack   = state_q == G0 && fin;
        m1_ack   = state_q == G1 && fin;
        m0_din   = state_q == G0 ? (tmo_hit ? ERR_DATA : bus_din) : 32'h0;
        m1_din   = state_q == G1 ? (tmo_hit ? ERR_DATA : bus_din) : 32'h0;
        gnt      = {state_q == G1, state_q == G0};
        tmo_err  = tmo_hit;
        tmo_addr = tmo_addr_q;
    end

    // last_q = 1 means m1 was served last, so m0 wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            tmo_addr_q <= '0;
        end else if (!act) begin
            cnt_q <= '0;
            if (m0_stb && (!m1_stb || last_q))
                state_q <= G0;
            else if (m1_stb)
                state_q <= G1;
        end else if (fin || !sel_stb) begin
            state_q <= IDLE;
            if (fin)
                last_q <= sel;
            if (tmo_hit)
                tmo_addr_q <= {sel_addr, 2'b00};
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: randomized and directed self-checking bench for bus_arb against a transaction-level model
module tb_bus_arb;
    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  stb = '0;
    logic [1:0]  we = '0;
    logic [21:0] addr [2];
    logic [31:0] dout [2];
    logic [31:0] din0, din1;
    logic        ack0, ack1;
    logic        bus_stb, bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din = '0;
    logic        bus_ack = 1'b0;
    logic [1:0]  gnt;
    logic        tmo_err;
    logic [23:0] tmo_addr;

    bus_arb #(.TMO_CYCLES(TMO), .TMO_W(8), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_stb(stb[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_dout(dout[0]),
        .m0_din(din0), .m0_ack(ack0),
        .m1_stb(stb[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_dout(dout[1]),
        .m1_din(din1), .m1_ack(ack1),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_ack(bus_ack),
        .gnt(gnt), .tmo_err(tmo_err), .tmo_addr(tmo_addr)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: owner 0 = idle, 1 = m0, 2 = m1; last = index of last served master;
    // age = 1-based grant cycle number of the current transfer.
    int          owner = 0;
    int          last = 1;
    int          age = 0;
    logic [23:0] m_taddr = '0;
    logic [1:0]  exp_ack = '0;

    task automatic cyc();
        int          g, n_owner, n_last, n_age;
        logic        sg, ackd, tmo;
        logic [23:0] n_taddr;
        @(negedge clk);
        if (!rst_n) begin
            owner = 0; last = 1; age = 0; m_taddr = '0;
        end
        g    = owner == 2 ? 1 : 0;
        sg   = stb[g];
        ackd = owner != 0 && sg && bus_ack;
        tmo  = owner != 0 && sg && !bus_ack && age == TMO;
        exp_ack[0] = owner == 1 && (ackd || tmo);
        exp_ack[1] = owner == 2 && (ackd || tmo);
        chk("gnt", 32'(gnt), owner == 1 ? 32'd1 : owner == 2 ? 32'd2 : 32'd0);
        chk("bus_stb", 32'(bus_stb), 32'(owner != 0 && sg && !tmo));
        chk("bus_we", 32'(bus_we), 32'(owner != 0 && we[g]));
        chk("bus_addr", 32'(bus_addr), 32'(addr[g]));
        chk("bus_dout", bus_dout, dout[g]);
        chk("m0_ack", 32'(ack0), 32'(exp_ack[0]));
        chk("m1_ack", 32'(ack1), 32'(exp_ack[1]));
        chk("m0_din", din0, owner == 1 ? (tmo ? ERR : bus_din) : 32'h0);
        chk("m1_din", din1, owner == 2 ? (tmo ? ERR : bus_din) : 32'h0);
        chk("tmo_err", 32'(tmo_err), 32'(tmo));
        chk("tmo_addr", 32'(tmo_addr), 32'(m_taddr));
        n_owner = owner; n_last = last; n_age = age; n_taddr = m_taddr;
        if (owner != 0) begin
            if (ackd || tmo) begin
                n_last = g;
                n_owner = 0;
                if (tmo) n_taddr = {addr[g], 2'b00};
            end else if (!sg) begin
                n_owner = 0;
            end else begin
                n_age = age + 1;
            end
        end else begin
            n_age = 1;
            if (stb[0] && (!stb[1] || last == 1)) n_owner = 1;
            else if (stb[1]) n_owner = 2;
        end
        @(posedge clk);
        if (rst_n) begin
            owner = n_owner; last = n_last; age = n_age; m_taddr = n_taddr;
        end
        #1;
    endtask

    task automatic new_req(input int k);
        stb[k]  = 1'b1;
        we[k]   = 1'($urandom_range(1));
        addr[k] = 22'($urandom);
        dout[k] = $urandom;
    endtask

    int ack_pct;

    initial begin
        addr[0] = '0; addr[1] = '0; dout[0] = '0; dout[1] = '0;
        // reset state, then m0 read @0x000100 acked on grant cycle 3
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1; stb[0] = 1'b1; addr[0] = 22'h000040;
        repeat (3) cyc();
        bus_ack = 1'b1; bus_din = 32'h11223344;
        cyc();
        stb[0] = 1'b0; bus_ack = 1'b0;
        cyc();
        // both masters continuously requesting, immediate ack, m0 first after reset
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; stb = 2'b11; dout[0] = 32'h01010101; dout[1] = 32'h02020202;
        addr[1] = 22'h2AAAAA; bus_ack = 1'b1; bus_din = 32'h55AA55AA;
        repeat (9) cyc();
        stb = 2'b00; bus_ack = 1'b0;
        cyc();
        // m1 write 0xCAFEF00D @0xFFFFC0 acked in first grant cycle
        stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 22'h3FFFF0; dout[1] = 32'hCAFEF00D; bus_ack = 1'b1;
        repeat (2) cyc();
        stb[1] = 1'b0; we[1] = 1'b0; bus_ack = 1'b0;
        cyc();
        // timeout: slave never acks m0 @0x123458
        stb[0] = 1'b1; addr[0] = 22'h048D16; bus_din = 32'h77777777;
        repeat (9) cyc();
        stb[0] = 1'b0;
        repeat (2) cyc();
        // ack arrives exactly on grant cycle 8: normal completion
        stb[0] = 1'b1; addr[0] = 22'h000123;
        repeat (8) cyc();
        bus_ack = 1'b1;
        cyc();
        stb[0] = 1'b0; bus_ack = 1'b0;
        cyc();
        // reset while G1 waits for ack, then m0 wins the first tie
        stb[1] = 1'b1; addr[1] = 22'h000001;
        repeat (3) cyc();
        rst_n = 1'b0; stb[0] = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        stb = 2'b00;
        cyc();
        // randomized traffic with varying slave latency and occasional resets
        for (int i = 0; i < 3000; i++) begin
            ack_pct = ((i / 500) % 2) != 0 ? 6 : 50;
            rst_n = (i % 700) != 350;
            for (int k = 0; k < 2; k++) begin
                if (stb[k] && exp_ack[k]) begin
                    if ($urandom_range(1) != 0) new_req(k);
                    else stb[k] = 1'b0;
                end else if (stb[k]) begin
                    if ($urandom_range(39) == 0) stb[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    new_req(k);
                end
            end
            bus_ack = $urandom_range(99) < ack_pct;
            bus_din = $urandom;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
